// File: rtl/div_iter_pkg.sv
// Shared definitions for the iterative EX-stage divider: widths, handshake levels and state encoding.
package div_iter_pkg;

    localparam int unsigned DIV_WIDTH = 32;

    localparam logic                 RstEnable         = 1'b0;
    localparam logic [DIV_WIDTH-1:0] ZeroWord          = '0;
    localparam logic                 DivResultReady    = 1'b1;
    localparam logic                 DivResultNotReady = 1'b0;
    localparam logic                 DivStart          = 1'b1;
    localparam logic                 DivStop           = 1'b0;

    typedef enum logic [1:0] {
        DIV_FREE   = 2'b00,
        DIV_BYZERO = 2'b01,
        DIV_ON     = 2'b10,
        DIV_END    = 2'b11
    } div_state_e;

endpackage

// File: rtl/div_iter_step.sv
// One restoring-division iteration: trial subtract of the divisor from the upper half, shift in a quotient bit.
module div_step
    import div_iter_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH
) (
    input  logic [2*WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0]   divisor_i,
    output logic [2*WIDTH:0]   dividend_nxt_c
);

    logic [WIDTH:0] minuend;

    always_comb begin
        minuend = {1'b0, dividend_i[2*WIDTH-1:WIDTH]} - {1'b0, divisor_i};
        if (minuend[WIDTH]) begin
            dividend_nxt_c = {dividend_i, 1'b0};
        end else begin
            dividend_nxt_c = {minuend[WIDTH-1:0], dividend_i[WIDTH-1:0], 1'b1};
        end
    end

endmodule

// File: rtl/div_iter.sv
// Iterative radix-2 restoring divider (DIV/DIVU), result {remainder, quotient}.
// Define DIV_ZERO_FLAG_EN to add the div_zero_o output flagging divide-by-zero results.
module div_iter
    import div_iter_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 signed_i,
    input  logic [WIDTH-1:0]     opdata1_i,
    input  logic [WIDTH-1:0]     opdata2_i,
    input  logic                 start_i,
    input  logic                 annul_i,
    output logic [2*WIDTH-1:0]   result_o,
    output logic                 ready_o
`ifdef DIV_ZERO_FLAG_EN
   ,output logic                 div_zero_o
`endif
);

    localparam int unsigned      CNT_W     = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    div_state_e           state_q,    state_d;
    logic [CNT_W-1:0]     cnt_q,      cnt_d;
    logic [2*WIDTH:0]     dividend_q, dividend_d;
    logic [WIDTH-1:0]     divisor_q,  divisor_d;
    logic                 op1_neg_q,  op1_neg_d;
    logic                 op2_neg_q,  op2_neg_d;
    logic [2*WIDTH-1:0]   result_q,   result_d;
    logic                 ready_q,    ready_d;
`ifdef DIV_ZERO_FLAG_EN
    logic                 byzero_q,   byzero_d;
    logic                 div_zero_q, div_zero_d;
`endif

    logic                 op1_neg_c;
    logic                 op2_neg_c;
    logic [WIDTH-1:0]     op1_abs_c;
    logic [WIDTH-1:0]     op2_abs_c;
    logic [WIDTH-1:0]     quo_c;
    logic [WIDTH-1:0]     rem_c;
    logic [2*WIDTH:0]     step_nxt_c;

    div_step #(.WIDTH(WIDTH)) u_step (
        .dividend_i     (dividend_q[2*WIDTH-1:0]),
        .divisor_i      (divisor_q),
        .dividend_nxt_c (step_nxt_c)
    );

    // Operand magnitudes at accept, sign fix-up of the finished result.
    always_comb begin
        op1_neg_c = signed_i & opdata1_i[WIDTH-1];
        op2_neg_c = signed_i & opdata2_i[WIDTH-1];
        op1_abs_c = op1_neg_c ? -opdata1_i : opdata1_i;
        op2_abs_c = op2_neg_c ? -opdata2_i : opdata2_i;
        quo_c     = dividend_q[WIDTH-1:0];
        rem_c     = dividend_q[2*WIDTH:WIDTH+1];
        if (op1_neg_q ^ op2_neg_q) begin
            quo_c = -quo_c;
        end
        if (op1_neg_q) begin
            rem_c = -rem_c;
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        dividend_d = dividend_q;
        divisor_d  = divisor_q;
        op1_neg_d  = op1_neg_q;
        op2_neg_d  = op2_neg_q;
        result_d   = result_q;
        ready_d    = ready_q;
`ifdef DIV_ZERO_FLAG_EN
        byzero_d   = byzero_q;
        div_zero_d = div_zero_q;
`endif
        case (state_q)
            DIV_FREE: begin
                result_d = '0;
                ready_d  = DivResultNotReady;
`ifdef DIV_ZERO_FLAG_EN
                div_zero_d = 1'b0;
`endif
                if (start_i == DivStart && !annul_i) begin
                    op1_neg_d = op1_neg_c;
                    op2_neg_d = op2_neg_c;
                    cnt_d     = '0;
                    if (opdata2_i == WIDTH'(ZeroWord)) begin
                        state_d = DIV_BYZERO;
`ifdef DIV_ZERO_FLAG_EN
                        byzero_d = 1'b1;
`endif
                    end else begin
                        state_d    = DIV_ON;
                        // Pre-shifted by one so W iterations consume every dividend bit.
                        dividend_d = {{WIDTH{1'b0}}, op1_abs_c, 1'b0};
                        divisor_d  = op2_abs_c;
`ifdef DIV_ZERO_FLAG_EN
                        byzero_d   = 1'b0;
`endif
                    end
                end
            end
            DIV_BYZERO: begin
                dividend_d = '0;
                state_d    = DIV_END;
            end
            DIV_ON: begin
                if (annul_i) begin
                    state_d = DIV_FREE;
                end else begin
                    dividend_d = step_nxt_c;
                    if (cnt_q == LAST_ITER) begin
                        state_d = DIV_END;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            DIV_END: begin
                if (annul_i || start_i == DivStop) begin
                    state_d  = DIV_FREE;
                    result_d = '0;
                    ready_d  = DivResultNotReady;
`ifdef DIV_ZERO_FLAG_EN
                    div_zero_d = 1'b0;
`endif
                end else begin
                    result_d = {rem_c, quo_c};
                    ready_d  = DivResultReady;
`ifdef DIV_ZERO_FLAG_EN
                    div_zero_d = byzero_q;
`endif
                end
            end
            default: begin
                state_d = DIV_FREE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RstEnable) begin
            state_q    <= DIV_FREE;
            cnt_q      <= '0;
            dividend_q <= '0;
            divisor_q  <= '0;
            op1_neg_q  <= 1'b0;
            op2_neg_q  <= 1'b0;
            result_q   <= '0;
            ready_q    <= DivResultNotReady;
`ifdef DIV_ZERO_FLAG_EN
            byzero_q   <= 1'b0;
            div_zero_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            dividend_q <= dividend_d;
            divisor_q  <= divisor_d;
            op1_neg_q  <= op1_neg_d;
            op2_neg_q  <= op2_neg_d;
            result_q   <= result_d;
            ready_q    <= ready_d;
`ifdef DIV_ZERO_FLAG_EN
            byzero_q   <= byzero_d;
            div_zero_q <= div_zero_d;
`endif
        end
    end

    assign result_o = result_q;
    assign ready_o  = ready_q;
`ifdef DIV_ZERO_FLAG_EN
    assign div_zero_o = div_zero_q;
`endif

endmodule

// File: tb/tb_div_iter.sv
// Scoreboard bench for div_iter: directed divisions, latency, annul and async-reset behaviour.
module tb_div_iter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        signed_i = 1'b0;
    logic [31:0] opdata1_i = '0;
    logic [31:0] opdata2_i = '0;
    logic        start_i = 1'b0;
    logic        annul_i = 1'b0;
    logic [63:0] result_o;
    logic        ready_o;
`ifdef DIV_ZERO_FLAG_EN
    logic        div_zero_o;
`endif

    div_iter #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .signed_i  (signed_i),
        .opdata1_i (opdata1_i),
        .opdata2_i (opdata2_i),
        .start_i   (start_i),
        .annul_i   (annul_i),
        .result_o  (result_o),
        .ready_o   (ready_o)
`ifdef DIV_ZERO_FLAG_EN
       ,.div_zero_o(div_zero_o)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] res;
        logic        dz;
        string       name;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   n_pass  = 0;
    int   n_total = 0;
    logic ready_prev = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Monitor: on each new ready, pop the oldest expectation and compare.
    always @(negedge clk) begin
        if (ready_o === 1'b1 && !ready_prev) begin
            if (sb.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_ready: got result %h with empty scoreboard", result_o);
            end else begin
                e = sb.pop_front();
                check({e.name, " result"}, result_o, e.res);
`ifdef DIV_ZERO_FLAG_EN
                check({e.name, " div_zero"}, 64'(div_zero_o), 64'(e.dz));
`endif
            end
        end
        ready_prev = (ready_o === 1'b1);
    end

    task automatic push_exp(input string name, input logic [63:0] res, input logic dz);
        exp_t x;
        x.res = res; x.dz = dz; x.name = name;
        sb.push_back(x);
    endtask

    // Drive a request, return after the accept edge with the operands scrambled.
    task automatic start_op(input logic s, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        signed_i = s; opdata1_i = a; opdata2_i = b; start_i = 1'b1;
        @(posedge clk);
        #1;
        signed_i  = ~s;
        opdata1_i = ~a;
        opdata2_i = a ^ 32'h5a5a_0001;
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (ready_o !== 1'b1 && n < 100);
    endtask

    task automatic run_div(input string name, input logic s, input logic [31:0] a, input logic [31:0] b,
                           input logic [63:0] res, input logic dz, input int lat);
        int n;
        push_exp(name, res, dz);
        start_op(s, a, b);
        wait_ready(n);
        check({name, " latency"}, 64'(n), 64'(lat));
        @(posedge clk); #1;
        check({name, " ready_hold"}, 64'(ready_o), 64'd1);
        @(negedge clk);
        start_i = 1'b0;
        @(posedge clk); #1;
        check({name, " ready_drop"}, 64'(ready_o), 64'd0);
        check({name, " result_clear"}, result_o, 64'd0);
    endtask

    initial begin
        #200_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int n;
        int n_hi;
        #1;
        check("reset ready", 64'(ready_o), 64'd0);
        check("reset result", result_o, 64'd0);
        repeat (3) @(negedge clk);
        rst = 1'b1;

        run_div("divu_100_7",  1'b0, 32'd100,       32'd7,         {32'd2,         32'd14},        1'b0, 33);
        run_div("div_m7_2",    1'b1, 32'hFFFF_FFF9, 32'd2,         {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 1'b0, 33);
        run_div("div_7_m2",    1'b1, 32'd7,         32'hFFFF_FFFE, {32'd1,         32'hFFFF_FFFD}, 1'b0, 33);
        run_div("div_m100_m7", 1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, {32'hFFFF_FFFE, 32'd14},        1'b0, 33);
        run_div("divu_3_10",   1'b0, 32'd3,         32'd10,        {32'd3,         32'd0},         1'b0, 33);
        run_div("div_by_zero", 1'b0, 32'd5,         32'd0,         64'd0,                          1'b1, 2);

        // Annul after ten iterations, then a fresh request straight away.
        start_op(1'b0, 32'd1000, 32'd3);
        repeat (10) @(posedge clk);
        @(negedge clk);
        annul_i = 1'b1;
        @(negedge clk);
        annul_i = 1'b0; start_i = 1'b0;
        n_hi = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (ready_o !== 1'b0) n_hi++;
        end
        check("annul no_ready", 64'(n_hi), 64'd0);
        run_div("after_annul", 1'b0, 32'd1000, 32'd7, {32'd6, 32'd142}, 1'b0, 33);

        // Asynchronous reset in the middle of an iteration sequence.
        start_op(1'b0, 32'd50, 32'd5);
        repeat (10) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("rst_mid_on ready", 64'(ready_o), 64'd0);
        check("rst_mid_on result", result_o, 64'd0);
        @(negedge clk);
        start_i = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        run_div("divu_max_1", 1'b0, 32'hFFFF_FFFF, 32'd1,         {32'd0, 32'hFFFF_FFFF}, 1'b0, 33);
        run_div("div_min_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'd0, 32'h8000_0000}, 1'b0, 33);

        // Asynchronous reset while a result is being presented.
        push_exp("divu_9_3", {32'd0, 32'd3}, 1'b0);
        start_op(1'b0, 32'd9, 32'd3);
        wait_ready(n);
        check("divu_9_3 latency", 64'(n), 64'd33);
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("rst_in_end ready", 64'(ready_o), 64'd0);
        check("rst_in_end result", result_o, 64'd0);
        start_i = 1'b0;
        @(negedge clk);
        rst = 1'b1;

        repeat (3) @(negedge clk);
        check("scoreboard drained", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
